// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/timer: FSM states, count modes,
// BCD limits and the load-value helpers used by the control FSM.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_UP0 = 2'b00,
        MODE_UPP = 2'b01,
        MODE_DN9 = 2'b10,
        MODE_DNP = 2'b11
    } mode_t;

    localparam logic [15:0] BCD_ZERO = 16'h0000;
    localparam logic [15:0] BCD_MAX  = 16'h9999;

    // Value restored by clear (and by auto-reload): up modes return to zero.
    function automatic logic [15:0] base_val(input mode_t m, input logic [15:0] p);
        case (m)
            MODE_DN9: return BCD_MAX;
            MODE_DNP: return p;
            default:  return BCD_ZERO;
        endcase
    endfunction

    // Value loaded when a run starts.
    function automatic logic [15:0] start_val(input mode_t m, input logic [15:0] p);
        case (m)
            MODE_UPP: return p;
            MODE_DN9: return BCD_MAX;
            MODE_DNP: return p;
            default:  return BCD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A press produces exactly one pulse, three clocks after the input rises.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s2_d  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            s2_d  <= s2;
            pulse <= s2 & ~s2_d;
        end
    end

endmodule

// File: rtl/sw_timer_ctrl.sv
// Stopwatch/timer control FSM: button pulses, tick prescaler and counter sequencing.
// Build option: define AUTO_RELOAD_EN to make down modes reload and keep running.
module sw_timer_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_set,
    input  logic        btn_ss,
    input  logic        btn_clr,
    input  logic [1:0]  mode,
    input  logic [15:0] preset,
    input  logic        cnt_term,
    output logic        cnt_load,
    output logic [15:0] cnt_load_val,
    output logic        cnt_en,
    output logic        cnt_up,
    output logic        running,
    output logic        done,
    output logic [2:0]  dbg_state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t        state;
    state_t        state_nxt;
    mode_t         mode_r;
    logic [15:0]   preset_r;
    logic [PW-1:0] presc;
    logic          tick_q;
    logic          entry_q;
    logic          set_p;
    logic          ss_p;
    logic          clr_p;

    btn_edge u_set (.clk(clk), .rst_n(rst_n), .btn(btn_set), .pulse(set_p));
    btn_edge u_ss  (.clk(clk), .rst_n(rst_n), .btn(btn_ss),  .pulse(ss_p));
    btn_edge u_clr (.clk(clk), .rst_n(rst_n), .btn(btn_clr), .pulse(clr_p));

    assign dbg_state = state;

    // cnt_load and cnt_en are mutually exclusive: every cnt_en path excludes a load.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = base_val(mode_r, preset_r);
        cnt_en       = 1'b0;
        running      = (state == ST_RUN);
        done         = (state == ST_DONE);
        cnt_up       = (state != ST_IDLE) & ~mode_r[1];
        if (clr_p) begin
            state_nxt = ST_IDLE;
            cnt_load  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_p) state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    cnt_load     = 1'b1;
                    cnt_load_val = start_val(mode_r, preset_r);
                    state_nxt    = ST_RUN;
                end
                ST_RUN: begin
                    // The step that would pass the terminal value is withheld.
                    if (tick_q && cnt_term) begin
`ifdef AUTO_RELOAD_EN
                        if (mode_r[1]) begin
                            cnt_load = 1'b1;
                            done     = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                        end
`else
                        state_nxt = ST_DONE;
`endif
                    end else if (entry_q && cnt_term) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_en = tick_q;
                        if (ss_p) state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (ss_p) state_nxt = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_r   <= MODE_UP0;
            preset_r <= BCD_ZERO;
            entry_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            entry_q <= (state == ST_LOAD);
            if (state == ST_IDLE && ss_p && !clr_p)
                mode_r <= mode_t'(mode);
            if ((state == ST_IDLE || state == ST_PAUSE) && set_p && !clr_p)
                preset_r <= preset;
        end
    end

    // A wrap while leaving RUN stays pending in tick_q and is issued on resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    tick_q <= (presc == PRESC_LAST);
                    presc  <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
                end
                ST_PAUSE, ST_DONE: ;
                default: begin
                    presc  <= '0;
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_timer_ctrl.sv
// Directed bench for sw_timer_ctrl with a cycle-level behavioural model and a BCD counter stand-in.
module tb_sw_timer_ctrl;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_set = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] preset = 16'h0000;
  logic        cnt_term;
  logic        cnt_load;
  logic [15:0] cnt_load_val;
  logic        cnt_en;
  logic        cnt_up;
  logic        running;
  logic        done;
  logic [2:0]  dbg_state;

  sw_timer_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .mode(mode), .preset(preset), .cnt_term(cnt_term), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .cnt_en(cnt_en), .cnt_up(cnt_up), .running(running),
    .done(done), .dbg_state(dbg_state)
  );

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  // ---------------- 4-digit BCD counter stand-in ----------------
  function automatic int bcd_to_int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int_to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  logic [15:0] env_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) env_cnt <= 16'h0000;
    else if (cnt_load) env_cnt <= cnt_load_val;
    else if (cnt_en) env_cnt <= int_to_bcd((bcd_to_int(env_cnt) + (cnt_up ? 1 : 9999)) % 10000);
  end
  assign cnt_term = cnt_up ? (env_cnt == 16'h9999) : (env_cnt == 16'h0000);

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int          en_log[$];
  int          load_cnt = 0;
  int          last_load_cyc = -1;
  logic [15:0] last_load_val = 16'h0000;
  int          done_rise = -1;
  logic        prev_done = 1'b0;

  function automatic int en_at(input int i);
    if (i < en_log.size()) return en_log[i];
    return -1;
  endfunction

  // ---------------- behavioural model + compare ----------------
  int          m_st;
  logic [1:0]  m_mode;
  logic [15:0] m_preset;
  int          m_k;
  logic [4:0]  h_set, h_ss, h_clr;
  logic        p_set, p_ss, p_clr;
  logic        e_load, e_en, e_run, e_done, e_up, slot;
  logic [15:0] e_val;
  int          nxt;

  function automatic logic [15:0] m_base(input logic [1:0] md, input logic [15:0] pr);
    if (md == 2'b10) return 16'h9999;
    if (md == 2'b11) return pr;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] m_start(input logic [1:0] md, input logic [15:0] pr);
    if (md == 2'b00) return 16'h0000;
    if (md == 2'b10) return 16'h9999;
    return pr;
  endfunction

  always @(negedge clk) begin : compare
    if (!rst_n) begin
      chk("rst_cnt_load", int'(cnt_load), 0);
      chk("rst_cnt_en", int'(cnt_en), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt_up", int'(cnt_up), 0);
      chk("rst_load_val", int'(cnt_load_val), 0);
      m_st = M_IDLE; m_mode = 2'b00; m_preset = 16'h0000; m_k = 0;
      h_set = '0; h_ss = '0; h_clr = '0;
      prev_done = 1'b0;
    end else begin
      // A press is seen as a pulse three cycles after the level first rises.
      h_set = {h_set[3:0], btn_set};
      h_ss  = {h_ss[3:0], btn_ss};
      h_clr = {h_clr[3:0], btn_clr};
      p_set = h_set[3] & ~h_set[4];
      p_ss  = h_ss[3] & ~h_ss[4];
      p_clr = h_clr[3] & ~h_clr[4];

      e_load = 1'b0; e_en = 1'b0; e_val = 16'h0000;
      e_run  = (m_st == M_RUN);
      e_done = (m_st == M_DONE);
      e_up   = (m_st != M_IDLE) ? ~m_mode[1] : 1'b0;
      slot   = (m_st == M_RUN) && (m_k > 0) && (m_k % DIV == 0);
      nxt    = m_st;
      if (p_clr) begin
        e_load = 1'b1; e_val = m_base(m_mode, m_preset); nxt = M_IDLE;
      end else if (m_st == M_IDLE) begin
        if (p_ss) nxt = M_LOAD;
      end else if (m_st == M_LOAD) begin
        e_load = 1'b1; e_val = m_start(m_mode, m_preset); nxt = M_RUN;
      end else if (m_st == M_RUN) begin
        if (slot && cnt_term) begin
`ifdef AUTO_RELOAD_EN
          if (m_mode[1]) begin
            e_load = 1'b1; e_val = m_base(m_mode, m_preset); e_done = 1'b1;
          end else nxt = M_DONE;
`else
          nxt = M_DONE;
`endif
        end else if (m_k == 0 && cnt_term) nxt = M_DONE;
        else begin
          e_en = slot;
          if (p_ss) nxt = M_PAUSE;
        end
      end else if (m_st == M_PAUSE) begin
        if (p_ss) nxt = M_RUN;
      end

      chk("cnt_load", int'(cnt_load), int'(e_load));
      chk("cnt_en", int'(cnt_en), int'(e_en));
      chk("running", int'(running), int'(e_run));
      chk("done", int'(done), int'(e_done));
      chk("cnt_up", int'(cnt_up), int'(e_up));
      if (e_load) chk("cnt_load_val", int'(cnt_load_val), int'(e_val));

      if (cnt_en) en_log.push_back(cyc);
      if (cnt_load) begin
        load_cnt++; last_load_cyc = cyc; last_load_val = cnt_load_val;
      end
      if (done && !prev_done) done_rise = cyc;
      prev_done = done;

      if (!p_clr && p_set && (m_st == M_IDLE || m_st == M_PAUSE)) m_preset = preset;
      if (!p_clr && p_ss && m_st == M_IDLE) m_mode = mode;
      if (m_st == M_LOAD) m_k = 0;
      else if (m_st == M_RUN) m_k++;
      m_st = nxt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic ss, input logic c);
    btn_set = s; btn_ss = ss; btn_clr = c;
    go_to(cyc + 2);
    btn_set = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0;
    go_to(cyc + 2);
  endtask

  // ---------------- directed scenarios ----------------
  int p, q, n0, lc;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Mode 00: load of 0000 four cycles after the press, first step ten cycles into RUN.
    go_to(10);
    mode = 2'b00; p = cyc; en_log.delete();
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 20);
    chk("s1_load_cyc", last_load_cyc, p + 4);
    chk("s1_load_val", int'(last_load_val), 0);
    chk("s1_first_en", en_at(0), p + 15);
    chk("s1_cnt_up", int'(cnt_up), 1);
    chk("s1_running", int'(running), 1);
    press(1'b0, 1'b0, 1'b1);

    // Mode 11 from preset 0003: three steps, DONE on the fourth slot, ss ignored in DONE.
    mode = 2'b11; preset = 16'h0003;
    press(1'b1, 1'b0, 1'b0);
    p = cyc; en_log.delete(); done_rise = -1;
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 60);
    chk("s2_en_count", en_log.size(), 3);
    chk("s2_last_en", en_at(2), p + 35);
    chk("s2_done_rise", done_rise, p + 46);
    press(1'b0, 1'b1, 1'b0);
    go_to(cyc + 10);
    chk("s2_done_held", int'(done), 1);
    chk("s2_en_after_ss", en_log.size(), 3);
    press(1'b0, 1'b0, 1'b1);
    chk("s2_clr_val", int'(last_load_val), 16'h0003);

    // Pause after 25 RUN cycles for 40 cycles; the partial tick resumes with 5 left.
    mode = 2'b00; p = cyc; en_log.delete();
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 26);
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 66);
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 80);
    chk("s3_en_count", en_log.size(), 3);
    chk("s3_en0", en_at(0), p + 15);
    chk("s3_en1", en_at(1), p + 25);
    chk("s3_en2", en_at(2), p + 75);

    // clr and ss together while running: clear wins, no pause.
    q = cyc; n0 = en_log.size();
    press(1'b0, 1'b1, 1'b1);
    go_to(q + 20);
    chk("s4_load_cyc", last_load_cyc, q + 3);
    chk("s4_load_val", int'(last_load_val), 0);
    chk("s4_running", int'(running), 0);
    chk("s4_no_en", en_log.size(), n0);

    // Mode 11 with preset 0000: DONE one cycle after RUN entry, no steps.
    mode = 2'b11; preset = 16'h0000;
    press(1'b1, 1'b0, 1'b0);
    p = cyc; en_log.delete(); done_rise = -1;
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 20);
    chk("s5_done_rise", done_rise, p + 6);
    chk("s5_en_count", en_log.size(), 0);
    chk("s5_done", int'(done), 1);
    press(1'b0, 1'b0, 1'b1);

    // Mode 01 starts from the preset, clears to 0000; mode 10 starts and clears to 9999.
    mode = 2'b01; preset = 16'h1234;
    press(1'b1, 1'b0, 1'b0);
    p = cyc;
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 8);
    chk("s6_up_load_cyc", last_load_cyc, p + 4);
    chk("s6_up_load_val", int'(last_load_val), 16'h1234);
    chk("s6_up_dir", int'(cnt_up), 1);
    press(1'b0, 1'b0, 1'b1);
    chk("s6_up_clr_val", int'(last_load_val), 16'h0000);
    mode = 2'b10; p = cyc;
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 8);
    chk("s6_dn_load_val", int'(last_load_val), 16'h9999);
    chk("s6_dn_dir", int'(cnt_up), 0);
    press(1'b0, 1'b0, 1'b1);
    chk("s6_dn_clr_val", int'(last_load_val), 16'h9999);

`ifdef AUTO_RELOAD_EN
    // Down mode reaching 0000 reloads and keeps running on the same tick grid.
    mode = 2'b11; preset = 16'h0002;
    press(1'b1, 1'b0, 1'b0);
    p = cyc; en_log.delete(); done_rise = -1;
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 50);
    chk("s7_reload_cyc", last_load_cyc, p + 35);
    chk("s7_reload_val", int'(last_load_val), 16'h0002);
    chk("s7_done_pulse", done_rise, p + 35);
    chk("s7_next_en", en_at(2), p + 45);
    chk("s7_running", int'(running), 1);
    press(1'b0, 1'b0, 1'b1);
`endif

    // Reset in the middle of a run aborts it; nothing is loaded at release.
    mode = 2'b00; p = cyc;
    press(1'b0, 1'b1, 1'b0);
    go_to(p + 20);
    rst_n = 1'b0;
    go_to(cyc + 3);
    rst_n = 1'b1;
    lc = load_cnt;
    go_to(cyc + 20);
    chk("s8_no_load", load_cnt - lc, 0);
    chk("s8_running", int'(running), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_timer_ctrl.md
# sw_timer_ctrl

Control FSM for the Basys3 stopwatch/timer. It takes the raw set/start-stop/clear buttons and the two-bit mode switches, and generates the centisecond tick. It drives the shared 4-digit BCD counter datapath with load, enable and direction, and decides when the run is finished. It sits between the board I/O and the counter, and is the only block that sequences that counter.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 100, count rate (one LSD step per tick)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_set  in  1  raw set-time button; async, level
- btn_ss  in  1  raw start/stop button; async, level
- btn_clr  in  1  raw clear button; async, level
- mode  in  2  00 up from 00.00, 01 up from preset, 10 down from 99.99, 11 down from preset
- preset  in  16  BCD preset, 4 digits, from switches
- cnt_term  in  1  counter is at terminal value: 9999 when counting up, 0000 when counting down
- cnt_load  out  1  one-cycle pulse; counter loads cnt_load_val
- cnt_load_val  out  16  BCD value to load
- cnt_en  out  1  one-cycle pulse per tick while running
- cnt_up  out  1  1 = increment, 0 = decrement
- running  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- Each button passes through a 2-flop synchronizer and a rising-edge detector, giving one internal pulse per press. Debouncing is done upstream.
- The preset register is 16 bits. It captures `preset` on a set pulse, only in IDLE or PAUSE. Set pulses in other states are ignored.
- Mode is latched on the IDLE→LOAD transition. Changing `mode` in any other state has no effect.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - ss pulse → LOAD.
  - clr pulse → stays in IDLE and issues a load of the mode base value.
- LOAD:
  - Asserts `cnt_load` for one cycle.
  - `cnt_load_val` is 0000 (mode 00), the preset register (01, 11) or 9999 (10).
  - Next state is RUN.
- RUN:
  - `cnt_en` pulses once per tick.
  - ss pulse → PAUSE.
  - `cnt_term` high in the same cycle as an `cnt_en` pulse → DONE. That final step is not issued.
  - `cnt_term` high on entry to RUN (e.g. preset 0000 in mode 11) → DONE on the next cycle, with no `cnt_en` issued.
- PAUSE:
  - ss pulse → RUN.
  - Ticks are suppressed.
- DONE:
  - Holds the counter.
  - ss pulse is ignored. Only clr leaves DONE.
- clr pulse in any state → IDLE and a one-cycle `cnt_load` of the mode base value.
  - Base value is 0000 for up modes and 9999/preset for down modes, per the latched mode.
  - clr has priority over ss and set in the same cycle.
- `cnt_up` = ~latched_mode[1]. It is held constant from LOAD until the next IDLE.

## Timing
- Button-to-pulse latency: 3 clk cycles (2 sync flops + edge register).
- Pulse-to-state-change latency: 1 cycle after the internal pulse.
- Prescaler:
  - Counts 0 to CLK_HZ/TICK_HZ−1. A tick fires on the wrap.
  - Reset to 0 on entry to RUN, so the first `cnt_en` comes exactly CLK_HZ/TICK_HZ cycles after RUN is entered.
  - Frozen in PAUSE and resumes from the held value, so no partial tick is lost.
  - Width is $clog2(CLK_HZ/TICK_HZ).
- `cnt_load` and `cnt_en` are never high in the same cycle.
- Reset values:
  - State IDLE, preset register 0000, latched mode 00, prescaler 0, synchronizers 0.
  - All outputs 0, `cnt_load_val` 0000.
- A reset asserted mid-run aborts immediately. No load is issued at release.

## Configuration
- AUTO_RELOAD_EN defined:
  - In down modes, reaching 0000 causes a one-cycle `cnt_load` of the latched base value, and the FSM stays in RUN.
  - The prescaler is not reset, so the tick period is preserved.
  - `done` pulses high for that one cycle only.
- AUTO_RELOAD_EN undefined: down modes terminate in DONE, as described under Operation. Up modes are identical in both builds.

## Structure
- Shared `stopwatch_pkg` contains:
  - state enum
  - mode enum (MODE_UP0, MODE_UPP, MODE_DN9, MODE_DNP)
  - BCD constants BCD_ZERO = 16'h0000 and BCD_MAX = 16'h9999
- Sub-module `btn_edge`: 2-flop synchronizer plus rising-edge pulse. Instantiated three times.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1, i.e. a tick every 10 cycles.
- Reset, mode 00, press ss → `cnt_load`=1 with value 0000 exactly 4 cycles after press; first `cnt_en` 10 cycles after RUN entry; `cnt_up`=1.
- Mode 11, set with preset 0003, ss, model counter → three `cnt_en` pulses, then `done`=1 with `cnt_term` high; further ss presses leave `done`=1.
- RUN 25 cycles, ss (PAUSE) for 40 cycles, ss again → next `cnt_en` 5 cycles after RUN re-entry; no `cnt_en` during PAUSE.
- clr and ss pressed in the same cycle while in RUN → state IDLE, `cnt_load` of base value, `running`=0, no PAUSE.
- Mode 11 with preset 0000, ss → DONE one cycle after RUN entry, zero `cnt_en` pulses.
- AUTO_RELOAD_EN, mode 10, counter reaches 0000 → `cnt_load` of 9999 plus a 1-cycle `done`, `running` stays 1, next `cnt_en` spaced exactly 10 cycles after the previous one.
